// File: rtl/kernel_buf_pkg.sv
// Shared types and sizing helpers for the kernel weight buffer and its index counter.
// No logic; pure declarations.
package kernel_buf_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    STREAM = 2'd2
  } kb_state_e;

  localparam int KB_K  = 3;
  localparam int KB_NW = KB_K * KB_K;

  // $clog2 that never returns 0, so single-entry ranges still get a 1-bit field
  function automatic int kb_clog2(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/kernel_idx_counter.sv
// Raster row/col counter: clear to (0,0), col-first advance on en_i, wraps after (K-1,K-1).
// Registered outputs, zero latency to term_o; no backpressure of its own (caller gates en_i).
module kernel_idx_counter
  import kernel_buf_pkg::*;
#(
  parameter int K    = KB_K,
  parameter int IDXW = kb_clog2(K)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr_i,
  input  logic            en_i,
  output logic [IDXW-1:0] row_o,
  output logic [IDXW-1:0] col_o,
  output logic            term_o
);

  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(K - 1);

  logic [IDXW-1:0] row_q, row_d;
  logic [IDXW-1:0] col_q, col_d;

  assign term_o = (row_q == LAST_IDX) && (col_q == LAST_IDX);
  assign row_o  = row_q;
  assign col_o  = col_q;

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clr_i) begin
      row_d = '0;
      col_d = '0;
    end else if (en_i) begin
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = term_o ? '0 : row_q + IDXW'(1);
      end else begin
        col_d = col_q + IDXW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

endmodule

// File: rtl/kernel_weight_buffer.sv
// NK-bank store of KxK signed weights: streamed load, raster replay with row/col tags.
// Replay starts the cycle after rd_start and holds registered outputs while w_ready is low.
module kernel_weight_buffer
  import kernel_buf_pkg::*;
#(
  parameter int K    = KB_K,
  parameter int WW   = 8,
  parameter int NK   = 4,
  parameter int KIDW = kb_clog2(NK),
  parameter int IDXW = kb_clog2(K)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            ld_start,
  input  logic [KIDW-1:0] ld_kid,
  input  logic            ld_valid,
  input  logic [WW-1:0]   ld_data,
  output logic            ld_ready,
  input  logic            rd_start,
  input  logic [KIDW-1:0] rd_kid,
  output logic            w_valid,
  output logic [WW-1:0]   w_data,
  output logic [IDXW-1:0] w_row,
  output logic [IDXW-1:0] w_col,
  output logic            w_last,
  input  logic            w_ready,
  output logic            busy,
  output logic [NK-1:0]   loaded,
  output logic            err
);

  localparam int NW = K * K;
  localparam int MW = NK * NW;
  localparam int AW = kb_clog2(MW);

  kb_state_e       state_q, state_d;
  logic [KIDW-1:0] bank_q, bank_d;
  logic [NK-1:0]   loaded_q, loaded_d;
  logic            err_q, err_d;
  logic [WW-1:0]   w_data_q, w_data_d;
  logic [WW-1:0]   mem_q [MW];

  logic [IDXW-1:0] row, col;
  logic            term;
  logic            cnt_clr, cnt_en, mem_we;
  logic [AW-1:0]   cur_addr, nxt_addr, rd_base;
  logic            ld_ok, rd_ok, ld_acc, rd_acc;

  kernel_idx_counter #(
    .K    (K),
    .IDXW (IDXW)
  ) u_idx (
    .clk    (clk),
    .rstn   (rstn),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .row_o  (row),
    .col_o  (col),
    .term_o (term)
  );

  always_comb begin
    cur_addr = AW'(int'(bank_q) * NW + int'(row) * K + int'(col));
    nxt_addr = term ? '0 : cur_addr + AW'(1);
    rd_base  = AW'(int'(rd_kid) * NW);
  end

  // A load request outranks a simultaneous read; the read is then reported as rejected
  assign ld_ok  = int'(ld_kid) < NK;
  assign rd_ok  = (int'(rd_kid) < NK) && loaded_q[rd_kid];
  assign ld_acc = ld_start && ld_ok;
  assign rd_acc = rd_start && rd_ok && !ld_acc;

  always_comb begin
    state_d  = state_q;
    bank_d   = bank_q;
    loaded_d = loaded_q;
    err_d    = 1'b0;
    w_data_d = w_data_q;
    cnt_clr  = 1'b0;
    cnt_en   = 1'b0;
    mem_we   = 1'b0;
    case (state_q)
      IDLE: begin
        err_d = (ld_start && !ld_ok) || (rd_start && !rd_acc);
        if (ld_acc) begin
          state_d          = LOAD;
          bank_d           = ld_kid;
          loaded_d[ld_kid] = 1'b0;
          cnt_clr          = 1'b1;
        end else if (rd_acc) begin
          state_d  = STREAM;
          bank_d   = rd_kid;
          cnt_clr  = 1'b1;
          w_data_d = mem_q[rd_base];
        end
      end
      LOAD: begin
        err_d = ld_start || rd_start;
        if (ld_valid) begin
          mem_we = 1'b1;
          cnt_en = 1'b1;
          if (term) begin
            loaded_d[bank_q] = 1'b1;
            state_d          = IDLE;
          end
        end
      end
      STREAM: begin
        err_d = ld_start || rd_start;
        if (w_ready) begin
          cnt_en = 1'b1;
          if (term) begin
            state_d  = IDLE;
            w_data_d = '0;
          end else begin
            w_data_d = mem_q[nxt_addr];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      bank_q   <= '0;
      loaded_q <= '0;
      err_q    <= 1'b0;
      w_data_q <= '0;
    end else begin
      state_q  <= state_d;
      bank_q   <= bank_d;
      loaded_q <= loaded_d;
      err_q    <= err_d;
      w_data_q <= w_data_d;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < MW; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[cur_addr] <= ld_data;
    end
  end

  assign ld_ready = (state_q == LOAD);
  assign w_valid  = (state_q == STREAM);
  assign busy     = (state_q != IDLE);
  assign w_data   = w_data_q;
  // The counter also walks during loads; hide that from the consumer side
  assign w_row    = w_valid ? row : '0;
  assign w_col    = w_valid ? col : '0;
  assign w_last   = w_valid && term;
  assign loaded   = loaded_q;
  assign err      = err_q;

endmodule

// File: tb/tb_kernel_weight_buffer.sv
// Directed bench for kernel_weight_buffer at K=3, WW=8, NK=4.
// Inputs change 1ns after posedge; outputs are sampled at that same point.
module tb_kernel_weight_buffer;

  localparam int K    = 3;
  localparam int WW   = 8;
  localparam int NK   = 4;
  localparam int KIDW = 2;
  localparam int IDXW = 2;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic            ld_start = 1'b0;
  logic [KIDW-1:0] ld_kid = '0;
  logic            ld_valid = 1'b0;
  logic [WW-1:0]   ld_data = '0;
  logic            ld_ready;
  logic            rd_start = 1'b0;
  logic [KIDW-1:0] rd_kid = '0;
  logic            w_valid;
  logic [WW-1:0]   w_data;
  logic [IDXW-1:0] w_row;
  logic [IDXW-1:0] w_col;
  logic            w_last;
  logic            w_ready = 1'b0;
  logic            busy;
  logic [NK-1:0]   loaded;
  logic            err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  kernel_weight_buffer #(
    .K    (K),
    .WW   (WW),
    .NK   (NK),
    .KIDW (KIDW),
    .IDXW (IDXW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .ld_start (ld_start),
    .ld_kid   (ld_kid),
    .ld_valid (ld_valid),
    .ld_data  (ld_data),
    .ld_ready (ld_ready),
    .rd_start (rd_start),
    .rd_kid   (rd_kid),
    .w_valid  (w_valid),
    .w_data   (w_data),
    .w_row    (w_row),
    .w_col    (w_col),
    .w_last   (w_last),
    .w_ready  (w_ready),
    .busy     (busy),
    .loaded   (loaded),
    .err      (err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // mode 0: 1..9, mode 1: -128/127 alternating, mode 2: 5,15,..,85
  function automatic logic [WW-1:0] pat(input int mode, input int i);
    case (mode)
      0:       return WW'(i + 1);
      1:       return (i % 2 == 0) ? 8'h80 : 8'h7F;
      default: return WW'(10 * i + 5);
    endcase
  endfunction

  function automatic logic [31:0] all_outs();
    return 32'({ld_ready, w_valid, w_data, w_row, w_col, w_last, busy, loaded, err});
  endfunction

  // Optionally fires a rd_start alongside ld_start, and/or during beat 'poke'
  task automatic load(input int kid, input int mode, input bit with_rd, input int poke);
    ld_start = 1'b1;
    ld_kid   = KIDW'(kid);
    if (with_rd) begin
      rd_start = 1'b1;
      rd_kid   = 2'd2;
    end
    tick();
    ld_start = 1'b0;
    rd_start = 1'b0;
    chk("ld_ready_on", ld_ready, 1);
    if (with_rd) begin
      chk("err_simul_start", err, 1);
      chk("wvalid_simul_start", w_valid, 0);
    end
    for (int i = 0; i < K * K; i++) begin
      ld_valid = 1'b1;
      ld_data  = pat(mode, i);
      chk("ld_ready_beat", ld_ready, 1);
      if (i == poke) begin
        rd_start = 1'b1;
        rd_kid   = 2'd2;
      end
      tick();
      rd_start = 1'b0;
      if (i == poke) begin
        chk("err_rd_in_load", err, 1);
        chk("busy_in_load", busy, 1);
        chk("wvalid_in_load", w_valid, 0);
      end
    end
    ld_valid = 1'b0;
    chk("ld_ready_off", ld_ready, 0);
    chk("busy_after_load", busy, 0);
  endtask

  task automatic replay(input int kid, input int mode, input bit toggle, input int exp_cycles);
    int n   = 0;
    int cyc = 0;
    rd_start = 1'b1;
    rd_kid   = KIDW'(kid);
    tick();
    rd_start = 1'b0;
    chk("wvalid_first", w_valid, 1);
    while (n < K * K && cyc < 64) begin
      w_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      chk("w_valid", w_valid, 1);
      chk("w_data", w_data, pat(mode, n));
      chk("w_row", w_row, n / K);
      chk("w_col", w_col, n % K);
      chk("w_last", w_last, 32'(n == K * K - 1));
      tick();
      cyc++;
      if (w_ready) n++;
    end
    w_ready = 1'b0;
    chk("replay_beats", n, K * K);
    chk("replay_cycles", cyc, exp_cycles);
    chk("wvalid_end", w_valid, 0);
    chk("busy_end", busy, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", all_outs(), 0);
    rstn = 1'b1;
    tick();

    // Read of an empty bank
    rd_start = 1'b1;
    rd_kid   = 2'd0;
    tick();
    rd_start = 1'b0;
    chk("err_empty_rd", err, 1);
    chk("loaded_empty", loaded, 4'b0000);
    chk("wvalid_empty_rd", w_valid, 0);
    tick();
    chk("err_one_cycle", err, 0);
    chk("busy_idle", busy, 0);

    load(2, 0, 1'b0, -1);
    chk("loaded_b2", loaded, 4'b0100);
    replay(2, 0, 1'b0, 9);
    replay(2, 0, 1'b1, 17);

    load(1, 1, 1'b0, -1);
    chk("loaded_b1b2", loaded, 4'b0110);
    replay(1, 1, 1'b0, 9);
    replay(2, 0, 1'b0, 9);

    load(3, 2, 1'b1, 4);
    chk("loaded_b123", loaded, 4'b1110);
    replay(3, 2, 1'b0, 9);

    // Reset in the middle of a load into bank 0
    ld_start = 1'b1;
    ld_kid   = 2'd0;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_data  = pat(0, i);
      tick();
    end
    ld_valid = 1'b0;
    chk("busy_mid_load", busy, 1);
    #2;
    rstn = 1'b0;
    #1;
    chk("reset_mid_outs", all_outs(), 0);
    tick();
    rstn = 1'b1;
    tick();
    chk("busy_after_rst", busy, 0);
    chk("loaded_after_rst", loaded, 4'b0000);
    rd_start = 1'b1;
    rd_kid   = 2'd0;
    tick();
    rd_start = 1'b0;
    chk("err_rd_after_rst", err, 1);
    chk("wvalid_rd_after_rst", w_valid, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/kernel_weight_buffer.md
Name: kernel_weight_buffer

Overview:
Parametrised kernel store and address sequencer for the convolution datapath. Holds NK kernels of K×K signed weights, each WW bits wide. Kernels are loaded through a streaming valid/ready port. On request, the block replays one selected kernel in raster order with row/col tags to the MAC array, under consumer back-pressure.

Parameters:
K, 3, kernel side length; kernel holds K*K weights (K >= 2)
WW, 8, weight width in bits
NK, 4, number of kernel banks (NK >= 1)
KIDW, $clog2(NK) (minimum 1), kernel-id width (derived)
IDXW, $clog2(K), row/col index width (derived)

Ports:
clk  in  1  system clock, all state updates on posedge
rstn  in  1  asynchronous active-low reset
ld_start  in  1  pulse: begin loading bank ld_kid
ld_kid  in  KIDW  target bank, sampled with ld_start
ld_valid  in  1  load beat valid
ld_data  in  WW  load weight
ld_ready  out  1  block accepts a load beat
rd_start  in  1  pulse: begin replaying bank rd_kid
rd_kid  in  KIDW  source bank, sampled with rd_start
w_valid  out  1  output weight valid
w_data  out  WW  output weight
w_row  out  IDXW  row index of w_data
w_col  out  IDXW  column index of w_data
w_last  out  1  marks the final weight (index K*K-1)
w_ready  in  1  consumer accepts the weight
busy  out  1  FSM not in IDLE
loaded  out  NK  per-bank "holds a complete kernel" flag
err  out  1  one-cycle pulse on a rejected request

Behaviour:
- Reset (async, rstn=0): FSM=IDLE; weight memory cleared to 0. The following outputs are 0: ld_ready, w_valid, w_data, w_row, w_col, w_last, busy, loaded, err. Reset mid-load or mid-replay aborts the operation immediately. A bank being loaded is left with loaded=0.
- FSM states: IDLE, LOAD, STREAM. A single engine means only one operation is active at a time.
- IDLE -> LOAD: ld_start=1 and ld_kid<NK. The bank is latched, loaded[bank] is cleared, and the index is reset to 0. ld_ready=1 from the next cycle.
- LOAD, per beat: each ld_valid&&ld_ready stores ld_data at index row*K+col. The index then advances col-first, raster order.
- LOAD -> IDLE: on the K*K-th beat, with the same edge setting loaded[bank]=1 and ld_ready=0. ld_valid without ld_ready is ignored.
- IDLE -> STREAM: rd_start=1, rd_kid<NK and loaded[rd_kid]=1. w_valid=1 on the next cycle, with index 0 (row 0, col 0).
- STREAM, output rules: w_data, w_row, w_col and w_last are registered and stay stable while w_valid&&!w_ready. The index advances only on w_valid&&w_ready. w_last=1 exactly when row=col=K-1.
- STREAM -> IDLE: after the w_last handshake. w_valid=0 on the following cycle, and no bubble is inserted between earlier beats. Full-rate replay of K*K weights takes K*K cycles after the first w_valid.
- Rejected requests produce an err pulse one cycle later, with state unchanged:
  - ld_start or rd_start with kid>=NK;
  - rd_start to a bank with loaded=0;
  - any ld_start or rd_start while busy=1.
- Simultaneous ld_start and rd_start in IDLE: the load wins and the read is rejected with an err pulse.
- Bank contents persist across replays. Reloading a bank overwrites it.
- Index wrap: col wraps K-1 -> 0 with row+1. Row never exceeds K-1 because the FSM exits first.

Decomposition:
- Shared package kernel_buf_pkg holds:
  - state enum typedef (IDLE, LOAD, STREAM);
  - helper function for derived widths (clog2 with minimum 1);
  - localparam for the weights-per-kernel count K*K.
- One sub-module, kernel_idx_counter: raster row/col counter with clear, enable and a terminal flag at (K-1, K-1). One instance is shared by the load and stream paths, cleared on every accepted start.

Test Plan:
- Reset, then rd_start with rd_kid=0 -> err=1 one cycle later; loaded=4'b0000; w_valid stays 0.
- Load bank 2 with weights 1..9 (K=3, continuous ld_valid) -> ld_ready high for 9 cycles; loaded=4'b0100. Then rd_start kid=2 with w_ready=1 -> 9 consecutive beats, w_data 1..9, (row,col) from (0,0) to (2,2), w_last only on w_data=9.
- Replay bank 2 with w_ready toggling 1,0 -> each weight held stable through stall cycles; the sequence is still 1..9 with no duplicates or drops.
- Load bank 1 with -128 and 127 alternating (WW=8) -> replay returns the exact signed bit patterns; bank 2 still replays 1..9.
- ld_start and rd_start asserted in the same IDLE cycle (kids 3 and 2) -> load proceeds (ld_ready=1), err=1, no w_valid. rd_start during LOAD -> err=1 and the load is unaffected.
- Assert rstn=0 after 4 load beats into bank 0 -> all outputs 0 and loaded[0]=0. After release, the FSM is in IDLE and rd_start kid=0 gives err.
